serial_seq_tx: RTL and testbench

//  Transmit side of the single-bit sequence link. Accepts parallel words over a valid/ready handshake and

---
 rtl/seq_link_pkg.sv | 37 +++
 rtl/seq_rx_model.sv | 36 +++
 rtl/serial_seq_tx.sv | 139 +++++++++++++
 tb/tb_serial_seq_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_link_pkg.sv
// Shared types and receiver-model helpers for the single-bit sequence link.
package seq_link_pkg;

    // Transmit controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SHIFT = 2'd2
    } tx_state_t;

    // Downstream receiver FSM states
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } rx_state_t;

    // Receiver next state for input a
    function automatic rx_state_t rx_next(input rx_state_t st, input logic a);
        rx_state_t nxt;
        case (st)
            S0:      nxt = a ? S1 : S0;
            S1:      nxt = a ? S2 : S3;
            S2:      nxt = a ? S3 : S0;
            S3:      nxt = a ? S0 : S2;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

    // Receiver Mealy output for input a
    function automatic logic rx_z(input rx_state_t st, input logic a);
        return (st == S0) & ~a;
    endfunction

endpackage

// File: rtl/seq_rx_model.sv
// Cycle model of the downstream sequence FSM, driven by the transmitted line.
module seq_rx_model
    import seq_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_i,
    input  logic       sync_clr_i,
    output logic [1:0] pred_st_o,
    output logic       pred_z_o
);

    rx_state_t st_q;
    rx_state_t st_d;

    // Advance the model; re-align to S0 when a preamble completes
    always_comb begin
        st_d = rx_next(st_q, a_i);
        if (sync_clr_i) begin
            st_d = S0;
        end
    end

    // Model state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q <= S0;
        end else begin
            st_q <= st_d;
        end
    end

    assign pred_st_o = st_q;
    assign pred_z_o  = rx_z(st_q, a_i);

endmodule

// File: rtl/serial_seq_tx.sv
// Serialiser for the sequence link: SYNC preamble of zeros, then payload LSB-first.
module serial_seq_tx
    import seq_link_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned SYNC_LEN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              a_out,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        pred_st,
    output logic              pred_z,
    output logic              pred_valid
);

    localparam int unsigned CNT_MAX = (DATA_W > SYNC_LEN) ? DATA_W : SYNC_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W - 1);

    // Three zeros are needed to reach S0 from any receiver state
    generate
        if (SYNC_LEN < 3 || DATA_W < 1) begin : g_bad_param
            $error("serial_seq_tx: SYNC_LEN must be >= 3 and DATA_W >= 1");
        end
    endgenerate

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              a_out_q, a_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pred_valid_q, pred_valid_d;
    logic              last_bit_c;
    logic              accept_c;
    logic              sync_done_c;

    // Handshake: open in IDLE and on the last payload bit for back-to-back frames
    assign last_bit_c = (state_q == SHIFT) && (cnt_q == BIT_LAST);
    assign in_ready   = rst_n & ((state_q == IDLE) | last_bit_c);
    assign accept_c   = in_valid & in_ready;

    // Controller next state, shift register, counter and registered outputs
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        a_out_d      = 1'b0;
        done_d       = 1'b0;
        pred_valid_d = pred_valid_q;
        sync_done_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d      = SHIFT;
                    cnt_d        = '0;
                    a_out_d      = shreg_q[0];
                    shreg_d      = shreg_q >> 1;
                    pred_valid_d = 1'b1;
                    sync_done_c  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (accept_c) begin
                        shreg_d = in_data;
                        state_d = SYNC;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    a_out_d = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            a_out_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pred_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            a_out_q      <= a_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pred_valid_q <= pred_valid_d;
        end
    end

    seq_rx_model u_rx_model (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_i        (a_out_q),
        .sync_clr_i (sync_done_c),
        .pred_st_o  (pred_st),
        .pred_z_o   (pred_z)
    );

    assign a_out      = a_out_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign pred_valid = pred_valid_q;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Scoreboard bench for serial_seq_tx: driver queues expected line bits, monitor checks them.
module tb_serial_seq_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       a_out;
    logic       busy;
    logic       frame_done;
    logic [1:0] pred_st;
    logic       pred_z;
    logic       pred_valid;

    serial_seq_tx #(.DATA_W(8), .SYNC_LEN(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_out      (a_out),
        .busy       (busy),
        .frame_done (frame_done),
        .pred_st    (pred_st),
        .pred_z     (pred_z),
        .pred_valid (pred_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       chk;
        logic [1:0] st;
        logic       last;
        logic [1:0] end_st;
    } item_t;

    item_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    logic  done_pend = 1'b0;
    logic [1:0] end_pend = 2'b00;
    int    idle_run = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Independent receivers started in every state, fed from the line
    function automatic logic [1:0] rx_step(input logic [1:0] s, input logic a);
        case ({s, a})
            3'b000: return 2'b00;
            3'b001: return 2'b01;
            3'b010: return 2'b11;
            3'b011: return 2'b10;
            3'b100: return 2'b00;
            3'b101: return 2'b11;
            3'b110: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    logic [1:0] rx_st [4];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) rx_st[k] <= 2'(k);
            else        rx_st[k] <= rx_step(rx_st[k], a_out);
        end
    end

    // Monitor: pops one expected line bit per busy cycle
    always @(negedge clk) begin
        item_t it;
        if (!rst_n) begin
            exp_q.delete();
            done_pend = 1'b0;
            idle_run  = 0;
        end else begin
            chk("frame_done", int'(frame_done), int'(done_pend));
            if (done_pend) chk("end_state", int'(pred_st), int'(end_pend));
            done_pend = 1'b0;
            if (pred_valid) begin
                for (int k = 0; k < 4; k++) chk($sformatf("rx_cosim%0d", k), int'(rx_st[k]), int'(pred_st));
            end
            if (busy) begin
                idle_run = 0;
                if (exp_q.size() == 0) begin
                    chk("busy_no_frame", int'(busy), 0);
                end else begin
                    it = exp_q.pop_front();
                    chk("a_out", int'(a_out), int'(it.a));
                    chk("in_ready_busy", int'(in_ready), int'(it.last));
                    if (it.chk) begin
                        chk("pred_st", int'(pred_st), int'(it.st));
                        chk("pred_z", int'(pred_z), int'((it.st == 2'b00) & ~it.a));
                        chk("pred_valid", int'(pred_valid), 1);
                    end
                    if (it.last) begin
                        done_pend = 1'b1;
                        end_pend  = it.end_st;
                    end
                end
            end else begin
                chk("idle_a_out", int'(a_out), 0);
                chk("idle_in_ready", int'(in_ready), 1);
                if (idle_run >= 3) begin
                    chk("idle_pred_st", int'(pred_st), 0);
                    chk("idle_pred_z", int'(pred_z), 1);
                end
                if (idle_run < 100) idle_run++;
            end
        end
    end

    // Offer a word; queue its expected line bits once in_ready is seen.
    // s[i] is the receiver state after payload bit i.
    task automatic send(input logic [7:0] w, input logic [7:0][1:0] s);
        item_t it;
        int    waited = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("ready_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            it.a = 1'b0; it.chk = 1'b0; it.st = 2'b00; it.last = 1'b0; it.end_st = 2'b00;
            exp_q.push_back(it);
        end
        for (int i = 0; i < 8; i++) begin
            it.a      = w[i];
            it.chk    = 1'b1;
            it.st     = (i == 0) ? 2'b00 : s[i-1];
            it.last   = (i == 7);
            it.end_st = s[7];
            exp_q.push_back(it);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_out", int'(a_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_pred_valid", int'(pred_valid), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_pred_st", int'(pred_st), 0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        do_reset();
        repeat (2) @(posedge clk);
        #1;

        // Single frame A5: states after bits 01,11,00,00,00,01,11,00
        send(8'hA5, {2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01});
        in_valid = 1'b0;
        drain();

        // Back-to-back FF then 01 with in_valid held
        send(8'hFF, {2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01});
        send(8'h01, {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01});
        in_valid = 1'b0;
        drain();

        // Backpressure: second word offered mid-frame
        send(8'h3C, {2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00});
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send(8'h96, {2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00});
        in_valid = 1'b0;
        drain();

        // Idle stretch
        repeat (20) @(posedge clk);
        #1;

        // Reset in the middle of SHIFT, then recover
        send(8'hA5, {2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01});
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        send(8'h96, {2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00});
        in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
